osd_text_writer: RTL and testbench

OSD_TEXT_WRITER -- requirements
Module: osd_text_writer

---
 rtl/osd_text_writer.sv | 133 +++++++++++++
 tb/tb_osd_text_writer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/osd_text_writer.sv
// osd_text_writer: byte-command text writer into an on-screen-display character RAM.
// Define OSD_AUTOHIDE_EN to hide the overlay TIMEOUT_FRAMES vblanks after the last command.
module osd_text_writer #(
    parameter int         SCREEN_COLS    = 48,
    parameter int         SCREEN_ROWS    = 32,
    parameter logic [7:0] BLANK_CHAR     = 8'h20,
    parameter int         TIMEOUT_FRAMES = 180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    input  logic        vblank,
    output logic [10:0] addr_a,
    output logic [7:0]  data_a,
    output logic        we_a,
    output logic        osd_active,
    output logic        busy
);
    localparam int CW = $clog2(SCREEN_COLS);
    localparam int RW = $clog2(SCREEN_ROWS);
    localparam logic [10:0] COLS11 = 11'(SCREEN_COLS);
    localparam logic [10:0] NCELL = 11'(SCREEN_COLS * SCREEN_ROWS);
    localparam logic [7:0] CMAX8 = 8'(SCREEN_COLS - 1);
    localparam logic [7:0] RMAX8 = 8'(SCREEN_ROWS - 1);
    localparam logic [CW-1:0] CMAX = CW'(SCREEN_COLS - 1);
    localparam logic [RW-1:0] RMAX = RW'(SCREEN_ROWS - 1);

    typedef enum logic [2:0] {IDLE, GET_COL, GET_ROW, GET_LIT, CLEAR} state_t;

    state_t state, state_n;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [10:0] clr_cnt, addr_r;
    logic [7:0] data_r;
    logic we_r, accept, wr, clr_done;

    assign cmd_ready = !reset && state != CLEAR;
    assign accept = cmd_valid && cmd_ready;
    assign clr_done = clr_cnt == NCELL - 11'd1;

    always_comb begin
        state_n = state;
        wr = 1'b0;
        if (state == CLEAR)
            state_n = clr_done ? IDLE : CLEAR;
        else if (accept)
            case (state)
                IDLE: begin
                    wr = cmd_data >= 8'h20;
                    state_n = cmd_data == 8'h01 ? GET_COL :
                              cmd_data == 8'h0C ? CLEAR :
                              cmd_data == 8'h1B ? GET_LIT : IDLE;
                end
                GET_COL: state_n = GET_ROW;
                GET_LIT: begin
                    wr = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
    end

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
            clr_cnt <= '0;
            addr_r <= '0;
            data_r <= '0;
            we_r <= 1'b0;
        end else begin
            we_r <= wr;
            if (wr) begin
                addr_r <= 11'(row) * COLS11 + 11'(col);
                data_r <= cmd_data;
                col <= col == CMAX ? '0 : col + 1'b1;
                if (col == CMAX)
                    row <= row == RMAX ? '0 : row + 1'b1;
            end
            if (accept && state == IDLE && (cmd_data == 8'h0A || cmd_data == 8'h0D))
                col <= '0;
            if (accept && state == IDLE && cmd_data == 8'h0A)
                row <= row == RMAX ? '0 : row + 1'b1;
            if (accept && state == GET_COL)
                col <= cmd_data > CMAX8 ? CMAX : CW'(cmd_data);
            if (accept && state == GET_ROW)
                row <= cmd_data > RMAX8 ? RMAX : RW'(cmd_data);
            if (state == CLEAR) begin
                clr_cnt <= clr_done ? '0 : clr_cnt + 11'd1;
                if (clr_done) begin
                    col <= '0;
                    row <= '0;
                end
            end
        end
    end

    // Sweep drives the RAM port directly; outputs are forced quiet while reset is held.
    assign we_a = !reset && (state == CLEAR || we_r);
    assign addr_a = reset ? '0 : state == CLEAR ? clr_cnt : addr_r;
    assign data_a = reset ? '0 : state == CLEAR ? BLANK_CHAR : data_r;
    assign busy = !reset && state == CLEAR;

`ifdef OSD_AUTOHIDE_EN
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
    logic [TW-1:0] timer;
    logic vb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
            vb_q <= 1'b0;
        end else begin
            vb_q <= vblank;
            if (accept)
                timer <= TW'(TIMEOUT_FRAMES);
            else if (vblank && !vb_q && timer != '0)
                timer <= timer - 1'b1;
        end
    end

    assign osd_active = !reset && timer != '0;
`else
    logic vblank_unused;
    assign vblank_unused = vblank;
    assign osd_active = !reset;
`endif
endmodule

// File: tb/tb_osd_text_writer.sv
// tb_osd_text_writer: directed stimulus with a write scoreboard for osd_text_writer.
module tb_osd_text_writer;
    logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, vblank = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic cmd_ready, we_a, osd_active, busy;
    logic [10:0] addr_a;
    logic [7:0] data_a;
    int checks = 0, errors = 0;
    int mcol = 0, mrow = 0;

    typedef struct {logic [10:0] a; logic [7:0] d;} wr_t;
    wr_t q[$];

`ifdef OSD_AUTOHIDE_EN
    localparam bit AH = 1'b1;
`else
    localparam bit AH = 1'b0;
`endif

    osd_text_writer #(.TIMEOUT_FRAMES(3)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .vblank(vblank), .addr_a(addr_a), .data_a(data_a),
        .we_a(we_a), .osd_active(osd_active), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_data = b;
        sync();
        cmd_valid = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        q.push_back('{11'(mrow * 48 + mcol), b});
        if (mcol == 47) begin
            mcol = 0;
            mrow = mrow == 31 ? 0 : mrow + 1;
        end else mcol++;
        send(b);
    endtask

    task automatic locate(input int c, input int r);
        send(8'h01);
        send(8'(c));
        send(8'(r));
        mcol = c > 47 ? 47 : c;
        mrow = r > 31 ? 31 : r;
    endtask

    task automatic drain(input string tag);
        repeat (4) sync();
        check(tag, q.size(), 0);
    endtask

    task automatic vpulse();
        vblank = 1'b1;
        sync();
        vblank = 1'b0;
        sync();
    endtask

    always @(negedge clk) begin : mon
        wr_t e;
        if (we_a === 1'b1) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed addr %0d data %0h, expected no write", addr_a, data_a);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                check("wr_addr", addr_a, e.a);
                check("wr_data", data_a, e.d);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_we", we_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_data", data_a, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_active", osd_active, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rel_ready", cmd_ready, 1);
        check("rel_active", osd_active, !AH);
        check("rel_busy", busy, 0);
        sync();

        put(8'h41);
        put(8'h42);
        @(negedge clk);
        check("b2b_we", we_a, 1);
        check("b2b_addr", addr_a, 1);
        @(negedge clk);
        check("b2b_idle", we_a, 0);
        sync();
        drain("q_b2b");

        locate(5, 3);
        put(8'h58);
        locate(200, 200);
        put(8'h5A);
        put(8'h43);
        drain("q_locate");

        locate(10, 2);
        send(8'h0D); mcol = 0;
        send(8'h0A); mcol = 0; mrow++;
        send(8'h05);
        send(8'h1F);
        put(8'h44);
        locate(46, 4);
        put(8'h61); put(8'h62); put(8'h63);
        drain("q_ctrl");

        send(8'h1B); put(8'h0A);
        send(8'h1B); put(8'h0C);
        put(8'h45);
        drain("q_lit");

        for (int i = 0; i < 1536; i++) q.push_back('{11'(i), 8'h20});
        send(8'h0C);
        for (int i = 0; i < 1536; i++) begin
            @(negedge clk);
            check("clr_busy", busy, 1);
            check("clr_ready", cmd_ready, 0);
        end
        @(negedge clk);
        check("clr_end_busy", busy, 0);
        check("clr_end_ready", cmd_ready, 1);
        sync();
        mcol = 0; mrow = 0;
        put(8'h41);
        drain("q_clear");

        for (int i = 0; i < 100; i++) q.push_back('{11'(i), 8'h20});
        send(8'h0C);
        repeat (100) sync();
        reset = 1'b1;
        sync(); sync();
        reset = 1'b0;
        mcol = 0; mrow = 0;
        repeat (20) sync();
        check("q_abort", q.size(), 0);
        put(8'h41);
        drain("q_after_abort");

        mcol = 0; mrow = 0;
        send(8'h01);
        reset = 1'b1; sync(); reset = 1'b0;
        put(8'h46);
        send(8'h1B);
        reset = 1'b1; sync(); reset = 1'b0;
        mcol = 0; mrow = 0;
        send(8'h05);
        put(8'h47);
        drain("q_seq_abort");

`ifdef OSD_AUTOHIDE_EN
        send(8'h00);
        vpulse(); vpulse();
        check("ah_after2", osd_active, 1);
        vpulse();
        check("ah_after3", osd_active, 0);
        send(8'h00);
        vpulse(); vpulse();
        send(8'h00);
        vpulse(); vpulse();
        check("ah_reload", osd_active, 1);
        vpulse();
        check("ah_reload_end", osd_active, 0);
`else
        vpulse(); vpulse(); vpulse(); vpulse();
        check("noah_active", osd_active, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
